ro_freq_meter: RTL and testbench

// - On-chip ring-oscillator frequency meter for the SOI standard-cell test die.
// - Consumes the output of an INVX1/NAND2X1 ring oscillator built from library cells.
// - Counts RO rising edges over a programmable window of CK cycles, so the

---
 rtl/ro_freq_meter_pkg.sv | 7 +
 rtl/ro_sync_edge.sv | 24 ++
 rtl/ro_freq_meter.sv | 84 ++++++++
 tb/tb_ro_freq_meter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_freq_meter_pkg.sv
// ro_freq_meter_pkg: FSM states and default sizing shared by the RO frequency meter.
package ro_freq_meter_pkg;
  typedef enum logic [1:0] {IDLE, MEAS, FIN} state_t;
  localparam int CNT_W_DEF = 16;
  localparam int WIN_W_DEF = 16;
  localparam int SYNC_MIN  = 2;
endpackage

// File: rtl/ro_sync_edge.sv
// ro_sync_edge: synchronises an asynchronous input and emits a one-cycle pulse per rising edge.
module ro_sync_edge
  import ro_freq_meter_pkg::*;
#(
  parameter int STAGES = SYNC_MIN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);
  logic [STAGES-1:0] sync;
  logic              hist;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      hist <= sync[STAGES-1];
    end
  end
  assign pulse = sync[STAGES-1] & ~hist;
endmodule

// File: rtl/ro_freq_meter.sv
// ro_freq_meter: counts ring-oscillator edges over a programmable window of CK cycles.
// Define RO_FREQ_METER_CONT_EN to add the CONT input for back-to-back windows.
module ro_freq_meter
  import ro_freq_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int WIN_W       = WIN_W_DEF,
  parameter int SYNC_STAGES = SYNC_MIN
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             RO_IN,
  input  logic             START,
  input  logic [WIN_W-1:0] WINDOW,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] COUNT,
  output logic             OVF
`ifdef RO_FREQ_METER_CONT_EN
  ,
  input  logic             CONT
`endif
);
  state_t           state, state_nx;
  logic [WIN_W-1:0] win, wcnt;
  logic [CNT_W-1:0] work;
  logic             sat, edge_p, cont, go, reload, fin_first;
`ifdef RO_FREQ_METER_CONT_EN
  assign cont = CONT;
`else
  assign cont = 1'b0;
`endif
  ro_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (CK),
    .rst_n(RN),
    .d    (RO_IN),
    .pulse(edge_p)
  );
  // DONE marks the cycle after FIN; the meter stays busy until the result is presented.
  assign BUSY      = (state != IDLE) || DONE;
  assign go        = (state == IDLE) && !DONE && START;
  assign fin_first = (state == FIN) && !DONE;
  // In continuous mode FIN is held a second cycle (the DONE cycle) before re-entering MEAS.
  assign reload    = (state == FIN) && DONE && cont;
  always_comb begin
    state_nx = state;
    if (go) state_nx = (WINDOW == '0) ? FIN : MEAS;
    else if (state == MEAS && wcnt == WIN_W'(1)) state_nx = FIN;
    else if (state == FIN) state_nx = !cont ? IDLE : (!DONE || win == '0) ? FIN : MEAS;
  end
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state <= IDLE;
      win   <= '0;
      wcnt  <= '0;
      work  <= '0;
      sat   <= 1'b0;
      COUNT <= '0;
      OVF   <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      state <= state_nx;
      DONE  <= fin_first;
      if (go) begin
        win  <= WINDOW;
        wcnt <= WINDOW;
        work <= '0;
        sat  <= 1'b0;
      end else if (reload) begin
        wcnt <= win;
        work <= '0;
        sat  <= 1'b0;
      end else if (state == MEAS) begin
        wcnt <= wcnt - WIN_W'(1);
        if (edge_p && &work) sat <= 1'b1;
        else if (edge_p) work <= work + CNT_W'(1);
      end
      if (fin_first) begin
        COUNT <= work;
        OVF   <= sat;
      end
    end
  end
endmodule

// File: tb/tb_ro_freq_meter.sv
// tb_ro_freq_meter: randomized self-checking bench; reference counts RO rises from a sampled trace.
module tb_ro_freq_meter;
  logic        clk = 0, rn = 0, ro = 0, start = 0;
  logic [15:0] window = '0;
  logic        busy, done, ovf, busy2, done2, ovf2;
  logic [15:0] count;
  logic [3:0]  count2;
`ifdef RO_FREQ_METER_CONT_EN
  logic        cont = 0;
`endif
  int checks = 0, passes = 0;
  int cyc = 0;
  int ro_mode = 0, ro_half = 2, ro_cnt = 0;
  bit ro_at [0:19999];

  ro_freq_meter dut (
    .CK(clk), .RN(rn), .RO_IN(ro), .START(start), .WINDOW(window),
    .BUSY(busy), .DONE(done), .COUNT(count), .OVF(ovf)
`ifdef RO_FREQ_METER_CONT_EN
    , .CONT(cont)
`endif
  );
  ro_freq_meter #(.CNT_W(4)) dut4 (
    .CK(clk), .RN(rn), .RO_IN(ro), .START(start), .WINDOW(window),
    .BUSY(busy2), .DONE(done2), .COUNT(count2), .OVF(ovf2)
`ifdef RO_FREQ_METER_CONT_EN
    , .CONT(cont)
`endif
  );

  always #5 clk = ~clk;

  // Mode 0: stopped, 1: square wave with ro_half cycles per level, 2: random levels of 1..4 cycles.
  always @(negedge clk) begin
    if (ro_mode == 0) ro = 1'b0;
    else if (ro_cnt <= 1) begin
      ro = ~ro;
      ro_cnt = (ro_mode == 1) ? ro_half : int'($urandom_range(1, 4));
    end else ro_cnt--;
  end

  always @(posedge clk) begin
    cyc++;
    if (cyc < 20000) ro_at[cyc] = ro;
  end

  // A rise first sampled at edge k is counted iff edge k+1 starts one of the window cycles [a, a+w-1].
  function automatic int model_n(input int a, input int w);
    int n = 0;
    for (int k = a - 1; k <= a + w - 2; k++) if (ro_at[k] && !ro_at[k-1]) n++;
    return n;
  endfunction

  task automatic start_meas(input int w, output int a);
    repeat (3) @(posedge clk);
    @(negedge clk);
    window = 16'(w);
    start = 1;
    @(posedge clk);
    #1;
    a = cyc;
    start = 0;
  endtask

  task automatic wait_done(input int a, input int bound, output int lat);
    lat = -1;
    for (int i = 0; i < bound && lat < 0; i++) begin
      @(posedge clk);
      #1;
      if (done) lat = cyc - a;
    end
  endtask

  task automatic test_reset;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passes++;
    checks++; if (count !== 16'd0) $display("FAIL reset_count got %0d want 0", count); else passes++;
    checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else passes++;
    checks++; if (count2 !== 4'd0 || ovf2 !== 1'b0) $display("FAIL reset_narrow got %0d/%b want 0/0", count2, ovf2); else passes++;
    @(negedge clk);
    rn = 1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_ro_f4;
    int a, lat, n;
    ro_mode = 1; ro_half = 2;
    repeat (8) @(posedge clk);
    start_meas(100, a);
    wait_done(a, 140, lat);
    n = model_n(a, 100);
    checks++; if (lat != 101) $display("FAIL f4_latency got %0d want 101", lat); else passes++;
    checks++; if (int'(count) != n) $display("FAIL f4_count got %0d want %0d", count, n); else passes++;
    checks++; if (count < 24 || count > 26) $display("FAIL f4_count_range got %0d want 25+/-1", count); else passes++;
    checks++; if (ovf !== 1'b0) $display("FAIL f4_ovf got %b want 0", ovf); else passes++;
    checks++; if (count2 !== 4'd15 || ovf2 !== 1'b1) $display("FAIL f4_narrow got %0d/%b want 15/1", count2, ovf2); else passes++;
  endtask

  task automatic test_window0;
    int a, lat, bc;
    start_meas(0, a);
    bc = busy ? 1 : 0;
    lat = -1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (busy) bc++;
      if (done && lat < 0) lat = cyc - a;
    end
    checks++; if (lat != 1) $display("FAIL w0_latency got %0d want 1", lat); else passes++;
    checks++; if (bc != 2) $display("FAIL w0_busy_cycles got %0d want 2", bc); else passes++;
    checks++; if (count !== 16'd0 || ovf !== 1'b0) $display("FAIL w0_result got %0d/%b want 0/0", count, ovf); else passes++;
  endtask

  task automatic test_saturation;
    int a, lat, n;
    ro_mode = 1; ro_half = 1;
    repeat (6) @(posedge clk);
    start_meas(40, a);
    wait_done(a, 80, lat);
    n = model_n(a, 40);
    checks++; if (done2 !== 1'b1) $display("FAIL sat_done_narrow got %b want 1", done2); else passes++;
    checks++; if (count2 !== 4'd15 || ovf2 !== 1'b1) $display("FAIL sat_narrow got %0d/%b want 15/1", count2, ovf2); else passes++;
    checks++; if (int'(count) != n || ovf !== 1'b0) $display("FAIL sat_wide got %0d/%b want %0d/0", count, ovf, n); else passes++;
    ro_mode = 0;
    repeat (6) @(posedge clk);
    start_meas(10, a);
    wait_done(a, 40, lat);
    checks++; if (lat != 11) $display("FAIL stopped_latency got %0d want 11", lat); else passes++;
    checks++; if (count2 !== 4'd0 || ovf2 !== 1'b0) $display("FAIL stopped_narrow got %0d/%b want 0/0", count2, ovf2); else passes++;
    checks++; if (count !== 16'd0) $display("FAIL stopped_wide got %0d want 0", count); else passes++;
  endtask

  task automatic test_random;
    int a, lat, n, w;
    ro_mode = 2;
    for (int it = 0; it < 8; it++) begin
      w = int'($urandom_range(1, 200));
      start_meas(w, a);
      wait_done(a, w + 20, lat);
      n = model_n(a, w);
      checks++; if (lat != w + 1) $display("FAIL rnd%0d_latency got %0d want %0d", it, lat, w + 1); else passes++;
      checks++; if (int'(count) != n || ovf !== 1'b0) $display("FAIL rnd%0d_count got %0d/%b want %0d/0", it, count, ovf, n); else passes++;
      checks++; if (int'(count2) != ((n > 15) ? 15 : n) || ovf2 !== (n > 15))
        $display("FAIL rnd%0d_narrow got %0d/%b want %0d/%b", it, count2, ovf2, (n > 15) ? 15 : n, n > 15); else passes++;
    end
  endtask

  task automatic test_start_ignored;
    int a, lat, nd, n;
    ro_mode = 1; ro_half = 2;
    start_meas(50, a);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1;
    window = 16'd3;
    @(posedge clk);
    #1;
    start = 0;
    nd = 0; lat = -1;
    while (cyc < a + 80) begin
      @(posedge clk);
      #1;
      if (done) begin
        nd++;
        if (lat < 0) lat = cyc - a;
      end
    end
    n = model_n(a, 50);
    checks++; if (lat != 51) $display("FAIL restart_latency got %0d want 51", lat); else passes++;
    checks++; if (nd != 1) $display("FAIL restart_done_count got %0d want 1", nd); else passes++;
    checks++; if (int'(count) != n) $display("FAIL restart_count got %0d want %0d", count, n); else passes++;
  endtask

  task automatic test_abort;
    int a, nd;
    ro_mode = 0;
    start_meas(50, a);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rn = 0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_flags got %b%b want 00", busy, done); else passes++;
    checks++; if (count !== 16'd0 || ovf !== 1'b0) $display("FAIL abort_result got %0d/%b want 0/0", count, ovf); else passes++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rn = 1;
    nd = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    checks++; if (nd != 0) $display("FAIL abort_done got %0d want 0", nd); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passes++;
  endtask

`ifdef RO_FREQ_METER_CONT_EN
  task automatic test_cont;
    int a, nd, idle_busy, t [4];
    ro_mode = 1; ro_half = 2;
    repeat (8) @(posedge clk);
    cont = 1;
    start_meas(20, a);
    nd = 0; idle_busy = 0;
    for (int i = 0; i < 120 && nd < 3; i++) begin
      @(posedge clk);
      #1;
      if (!busy) idle_busy++;
      if (done) begin
        t[nd] = cyc;
        nd++;
        checks++; if (count !== 16'd5) $display("FAIL cont_count%0d got %0d want 5", nd, count); else passes++;
      end
    end
    checks++; if (nd != 3) $display("FAIL cont_dones got %0d want 3", nd); else passes++;
    checks++; if (t[0] - a != 21) $display("FAIL cont_first got %0d want 21", t[0] - a); else passes++;
    checks++; if (t[1] - t[0] != 22 || t[2] - t[1] != 22) $display("FAIL cont_period got %0d,%0d want 22", t[1] - t[0], t[2] - t[1]); else passes++;
    checks++; if (idle_busy != 0) $display("FAIL cont_busy_drop got %0d want 0", idle_busy); else passes++;
    repeat (5) @(posedge clk);
    #1;
    cont = 0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        nd++;
        t[3] = cyc;
      end
    end
    checks++; if (nd != 1 || t[3] - t[2] != 22) $display("FAIL cont_final got %0d dones at +%0d want 1 at +22", nd, t[3] - t[2]); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL cont_idle got %b want 0", busy); else passes++;
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ro_f4();
    test_window0();
    test_saturation();
    test_random();
    test_start_ignored();
    test_abort();
`ifdef RO_FREQ_METER_CONT_EN
    test_cont();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
